// File: rtl/aes_iterative_core_pkg.sv
// Shared types and GF(2^8) helpers for the iterative AES core.
// The S-box is computed (inverse plus affine map) rather than tabulated.
package aes_iterative_core_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StRound = 2'd1,
    StDone  = 2'd2
  } core_state_e;

  function automatic int unsigned nr_of(input int unsigned nk);
    return nk + 6;
  endfunction

  function automatic logic nk_is_legal(input int unsigned nk);
    return (nk == 4) || (nk == 6) || (nk == 8);
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc;
    logic [7:0] p;
    acc = 8'h00;
    p   = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) acc = acc ^ p;
      p = xtime(p);
    end
    return acc;
  endfunction

  // a^254 is the multiplicative inverse; zero maps to zero as AES requires.
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] res;
    logic [7:0] base;
    res  = 8'h01;
    base = a;
    for (int i = 0; i < 8; i++) begin
      if (i != 0) res = gf_mul(res, base);
      base = gf_mul(base, base);
    end
    return res;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] a, input int unsigned n);
    return (a << n) | (a >> (8 - n));
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] b;
    b = gf_inv(a);
    return b ^ rotl8(b, 1) ^ rotl8(b, 2) ^ rotl8(b, 3) ^ rotl8(b, 4) ^ 8'h63;
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] a);
    return gf_inv(rotl8(a, 1) ^ rotl8(a, 3) ^ rotl8(a, 6) ^ 8'h05);
  endfunction

  function automatic logic [127:0] sub_bytes(input logic [127:0] s, input logic inv);
    logic [127:0] o;
    for (int i = 0; i < 16; i++) begin
      o[8*i +: 8] = inv ? inv_sbox(s[8*i +: 8]) : sbox(s[8*i +: 8]);
    end
    return o;
  endfunction

  // Byte n of the block (FIPS order) sits at bits [127-8n -: 8]; row r, column c is byte 4c+r.
  function automatic logic [127:0] shift_rows(input logic [127:0] s, input logic inv);
    logic [127:0] o;
    int unsigned  src;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        src = inv ? (c + 4 - r) % 4 : (c + r) % 4;
        o[127 - 8*(4*c + r) -: 8] = s[127 - 8*(4*src + r) -: 8];
      end
    end
    return o;
  endfunction

  function automatic logic [127:0] mix_columns(input logic [127:0] s, input logic inv);
    logic [127:0] o;
    logic [7:0]   coef [4];
    logic [7:0]   col  [4];
    logic [7:0]   acc;
    if (inv) coef = '{8'h0e, 8'h0b, 8'h0d, 8'h09};
    else     coef = '{8'h02, 8'h03, 8'h01, 8'h01};
    for (int c = 0; c < 4; c++) begin
      for (int k = 0; k < 4; k++) col[k] = s[127 - 8*(4*c + k) -: 8];
      for (int r = 0; r < 4; r++) begin
        acc = 8'h00;
        for (int k = 0; k < 4; k++) acc = acc ^ gf_mul(coef[(k + 4 - r) % 4], col[k]);
        o[127 - 8*(4*c + r) -: 8] = acc;
      end
    end
    return o;
  endfunction

endpackage

// File: rtl/aes_iterative_core_round_unit.sv
// One combinational AES round, forward or standard inverse, with the final-round
// MixColumns bypass.
module aes_round_unit
  import aes_iterative_core_pkg::*;
(
  input  logic [127:0] stateIn,
  input  logic [127:0] roundKey,
  input  logic         decrypt,
  input  logic         lastRound,
  output logic [127:0] stateOut
);

  logic [127:0] enc_shifted;
  logic [127:0] enc_mixed;
  logic [127:0] dec_keyed;
  logic [127:0] dec_mixed;

  always_comb begin
    enc_shifted = shift_rows(sub_bytes(stateIn, 1'b0), 1'b0);
    enc_mixed   = lastRound ? enc_shifted : mix_columns(enc_shifted, 1'b0);
    dec_keyed   = sub_bytes(shift_rows(stateIn, 1'b1), 1'b1) ^ roundKey;
    dec_mixed   = lastRound ? dec_keyed : mix_columns(dec_keyed, 1'b1);
    stateOut    = decrypt ? dec_mixed : (enc_mixed ^ roundKey);
  end

endmodule

// File: rtl/aes_iterative_core.sv
// Iterative AES-128/192/256 engine, one round per clock, with valid/ready on both sides
// and a wrapping count of delivered blocks.
module aes_iterative_core
  import aes_iterative_core_pkg::*;
#(
  parameter  int unsigned Nk      = 4,
  parameter  int unsigned COUNT_W = 16,
  localparam int unsigned Nr      = nr_of(Nk)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  inValid,
  output logic                  inReady,
  input  logic [127:0]          inData,
  input  logic                  inDecrypt,
  input  logic [(Nr+1)*128-1:0] keySchedule,
  output logic                  outValid,
  input  logic                  outReady,
  output logic [127:0]          outData,
  output logic                  outDecrypt,
  output logic                  busy,
  output logic [COUNT_W-1:0]    blockCount
);

  if (!nk_is_legal(Nk)) begin : g_bad_nk
    $error("aes_iterative_core: Nk must be 4, 6 or 8");
  end

  localparam logic [3:0] LastRound = 4'(Nr);

  core_state_e        fsm_q;
  logic [3:0]         round_q;
  logic               mode_q;
  logic [127:0]       state_q;
  logic [127:0]       out_data_q;
  logic               out_dec_q;
  logic [COUNT_W-1:0] count_q;

  logic [127:0] round_key;
  logic [127:0] round_out;
  logic         last_round;
  int unsigned  rk_idx;

  // rk0 occupies the top 128 bits of the schedule, rk[Nr] the bottom.
  always_comb begin
    rk_idx     = mode_q ? (Nr - 32'(round_q)) : 32'(round_q);
    round_key  = keySchedule[(Nr - rk_idx) * 128 +: 128];
    last_round = (round_q == LastRound);
  end

  aes_round_unit u_round (
    .stateIn  (state_q),
    .roundKey (round_key),
    .decrypt  (mode_q),
    .lastRound(last_round),
    .stateOut (round_out)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      fsm_q      <= StIdle;
      round_q    <= '0;
      mode_q     <= 1'b0;
      state_q    <= '0;
      out_data_q <= '0;
      out_dec_q  <= 1'b0;
      count_q    <= '0;
    end else begin
      unique case (fsm_q)
        StIdle: begin
          if (inValid) begin
            state_q <= inData ^ (inDecrypt ? keySchedule[127:0] : keySchedule[Nr*128 +: 128]);
            mode_q  <= inDecrypt;
            round_q <= 4'd1;
            fsm_q   <= StRound;
          end
        end
        StRound: begin
          state_q <= round_out;
          if (last_round) begin
            out_data_q <= round_out;
            out_dec_q  <= mode_q;
            round_q    <= '0;
            fsm_q      <= StDone;
          end else begin
            round_q <= round_q + 4'd1;
          end
        end
        StDone: begin
          if (outReady) begin
            count_q <= count_q + COUNT_W'(1);
            fsm_q   <= StIdle;
          end
        end
        default: fsm_q <= StIdle;
      endcase
    end
  end

  assign inReady    = (fsm_q == StIdle);
  assign outValid   = (fsm_q == StDone);
  assign busy       = (fsm_q != StIdle);
  assign outData    = out_data_q;
  assign outDecrypt = out_dec_q;
  assign blockCount = count_q;

endmodule

// File: tb/tb_aes_iterative_core.sv
// Bench: AES-128/192/256 cores run side by side on shared handshakes, checked against a
// byte-array AES model built from log/exp-generated tables.
module tb_aes_iterative_core;

  logic clk;
  logic reset;
  logic inValid;
  logic inDecrypt;
  logic outReady;
  logic [127:0] inData;
  logic [11*128-1:0] sched4;
  logic [13*128-1:0] sched6;
  logic [15*128-1:0] sched8;

  logic [2:0]   in_ready;
  logic [2:0]   out_valid;
  logic [2:0]   out_dec;
  logic [2:0]   busy;
  logic [127:0] out_data [3];
  logic [1:0]   cnt4;
  logic [15:0]  cnt6;
  logic [15:0]  cnt8;
  logic [15:0]  cnt_w [3];

  assign cnt_w[0] = {14'd0, cnt4};
  assign cnt_w[1] = cnt6;
  assign cnt_w[2] = cnt8;

  int vectors;
  int miscompares;

  logic [7:0]   sbox     [256];
  logic [7:0]   inv_sbox [256];
  logic [127:0] rk_tab   [3][15];
  logic [15:0]  exp_cnt  [3];
  logic [127:0] res_data [3];
  logic         res_dec  [3];
  logic [1:0]   wrap_seq [5];

  aes_iterative_core #(.Nk(4), .COUNT_W(2)) u_dut4 (
    .clk(clk), .reset(reset), .inValid(inValid), .inReady(in_ready[0]), .inData(inData),
    .inDecrypt(inDecrypt), .keySchedule(sched4), .outValid(out_valid[0]), .outReady(outReady),
    .outData(out_data[0]), .outDecrypt(out_dec[0]), .busy(busy[0]), .blockCount(cnt4)
  );

  aes_iterative_core #(.Nk(6), .COUNT_W(16)) u_dut6 (
    .clk(clk), .reset(reset), .inValid(inValid), .inReady(in_ready[1]), .inData(inData),
    .inDecrypt(inDecrypt), .keySchedule(sched6), .outValid(out_valid[1]), .outReady(outReady),
    .outData(out_data[1]), .outDecrypt(out_dec[1]), .busy(busy[1]), .blockCount(cnt6)
  );

  aes_iterative_core #(.Nk(8), .COUNT_W(16)) u_dut8 (
    .clk(clk), .reset(reset), .inValid(inValid), .inReady(in_ready[2]), .inData(inData),
    .inDecrypt(inDecrypt), .keySchedule(sched8), .outValid(out_valid[2]), .outReady(outReady),
    .outData(out_data[2]), .outDecrypt(out_dec[2]), .busy(busy[2]), .blockCount(cnt8)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] cnt_mask(input int k);
    return (k == 0) ? 16'h0003 : 16'hffff;
  endfunction

  function automatic logic [7:0] mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // Walk generator 3 and its inverse together to fill the S-box without any inversion.
  task automatic build_tables();
    logic [7:0] p;
    logic [7:0] q;
    logic [7:0] x;
    p = 8'h01;
    q = 8'h01;
    do begin
      p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
      q = q ^ {q[6:0], 1'b0};
      q = q ^ {q[5:0], 2'b0};
      q = q ^ {q[3:0], 4'b0};
      if (q[7]) q = q ^ 8'h09;
      x = q ^ {q[6:0], q[7]} ^ {q[5:0], q[7:6]} ^ {q[4:0], q[7:5]} ^ {q[3:0], q[7:4]};
      sbox[p] = x ^ 8'h63;
    end while (p != 8'h01);
    sbox[0] = 8'h63;
    for (int i = 0; i < 256; i++) inv_sbox[sbox[i]] = 8'(i);
  endtask

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox[w[31:24]], sbox[w[23:16]], sbox[w[15:8]], sbox[w[7:0]]};
  endfunction

  // FIPS-197 key expansion for each of the three key lengths, using leading bytes of key.
  task automatic set_key(input logic [255:0] key);
    logic [31:0] w [60];
    logic [31:0] t;
    logic [7:0]  rcon;
    int nk;
    int nr;
    for (int k = 0; k < 3; k++) begin
      nk   = 4 + 2 * k;
      nr   = nk + 6;
      rcon = 8'h01;
      for (int i = 0; i < nk; i++) w[i] = key[255 - 32*i -: 32];
      for (int i = nk; i < 4 * (nr + 1); i++) begin
        t = w[i-1];
        if (i % nk == 0) begin
          t    = sub_word({t[23:0], t[31:24]}) ^ {rcon, 24'h0};
          rcon = {rcon[6:0], 1'b0} ^ (rcon[7] ? 8'h1b : 8'h00);
        end else if (nk > 6 && i % nk == 4) begin
          t = sub_word(t);
        end
        w[i] = w[i-nk] ^ t;
      end
      for (int r = 0; r < 15; r++) begin
        rk_tab[k][r] = (r <= nr) ? {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]} : 128'h0;
      end
    end
    for (int r = 0; r <= 10; r++) sched4[(10 - r)*128 +: 128] = rk_tab[0][r];
    for (int r = 0; r <= 12; r++) sched6[(12 - r)*128 +: 128] = rk_tab[1][r];
    for (int r = 0; r <= 14; r++) sched8[(14 - r)*128 +: 128] = rk_tab[2][r];
  endtask

  function automatic logic [127:0] ref_aes(input int k, input logic [127:0] blk, input logic dec);
    logic [7:0]   s [16];
    logic [7:0]   t [16];
    logic [7:0]   a0, a1, a2, a3;
    logic [127:0] rk;
    logic [127:0] res;
    int nr;
    nr = 10 + 2 * k;
    for (int i = 0; i < 16; i++) s[i] = blk[127 - 8*i -: 8];
    if (!dec) begin
      rk = rk_tab[k][0];
      for (int i = 0; i < 16; i++) s[i] = s[i] ^ rk[127 - 8*i -: 8];
      for (int r = 1; r <= nr; r++) begin
        for (int i = 0; i < 16; i++) t[i] = sbox[s[i]];
        for (int c = 0; c < 4; c++)
          for (int w = 0; w < 4; w++) s[4*c + w] = t[4*((c + w) % 4) + w];
        if (r < nr) begin
          for (int c = 0; c < 4; c++) begin
            a0 = s[4*c]; a1 = s[4*c+1]; a2 = s[4*c+2]; a3 = s[4*c+3];
            s[4*c]   = mul(a0, 8'h02) ^ mul(a1, 8'h03) ^ a2 ^ a3;
            s[4*c+1] = a0 ^ mul(a1, 8'h02) ^ mul(a2, 8'h03) ^ a3;
            s[4*c+2] = a0 ^ a1 ^ mul(a2, 8'h02) ^ mul(a3, 8'h03);
            s[4*c+3] = mul(a0, 8'h03) ^ a1 ^ a2 ^ mul(a3, 8'h02);
          end
        end
        rk = rk_tab[k][r];
        for (int i = 0; i < 16; i++) s[i] = s[i] ^ rk[127 - 8*i -: 8];
      end
    end else begin
      rk = rk_tab[k][nr];
      for (int i = 0; i < 16; i++) s[i] = s[i] ^ rk[127 - 8*i -: 8];
      for (int r = nr - 1; r >= 0; r--) begin
        for (int c = 0; c < 4; c++)
          for (int w = 0; w < 4; w++) t[4*c + w] = s[4*((c + 4 - w) % 4) + w];
        rk = rk_tab[k][r];
        for (int i = 0; i < 16; i++) s[i] = inv_sbox[t[i]] ^ rk[127 - 8*i -: 8];
        if (r > 0) begin
          for (int c = 0; c < 4; c++) begin
            a0 = s[4*c]; a1 = s[4*c+1]; a2 = s[4*c+2]; a3 = s[4*c+3];
            s[4*c]   = mul(a0, 8'h0e) ^ mul(a1, 8'h0b) ^ mul(a2, 8'h0d) ^ mul(a3, 8'h09);
            s[4*c+1] = mul(a0, 8'h09) ^ mul(a1, 8'h0e) ^ mul(a2, 8'h0b) ^ mul(a3, 8'h0d);
            s[4*c+2] = mul(a0, 8'h0d) ^ mul(a1, 8'h09) ^ mul(a2, 8'h0e) ^ mul(a3, 8'h0b);
            s[4*c+3] = mul(a0, 8'h0b) ^ mul(a1, 8'h0d) ^ mul(a2, 8'h09) ^ mul(a3, 8'h0e);
          end
        end
      end
    end
    for (int i = 0; i < 16; i++) res[127 - 8*i -: 8] = s[i];
    return res;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Called at a negedge with every core idle; returns at the negedge after acceptance.
  task automatic launch(input logic [127:0] d, input logic dec);
    check("accept_ready", 128'(in_ready), 128'(3'b111));
    inData    = d;
    inDecrypt = dec;
    inValid   = 1'b1;
    @(posedge clk);
    @(negedge clk);
    inValid   = 1'b0;
    inDecrypt = ~dec;
    inData    = rand128();
    check("run_busy", 128'(busy), 128'(3'b111));
    check("run_not_ready", 128'(in_ready), 128'(3'b000));
  endtask

  task automatic collect(input logic [127:0] d, input logic dec, input bit bp);
    int lat  [3];
    bit seen [3];
    int c;
    for (int k = 0; k < 3; k++) begin
      lat[k]  = 0;
      seen[k] = 1'b0;
    end
    c = 0;
    while (!(seen[0] && seen[1] && seen[2]) && c < 40) begin
      @(posedge clk);
      @(negedge clk);
      c++;
      for (int k = 0; k < 3; k++) begin
        if (!seen[k] && out_valid[k]) begin
          seen[k]     = 1'b1;
          lat[k]      = c;
          res_data[k] = out_data[k];
          res_dec[k]  = out_dec[k];
        end
      end
    end
    for (int k = 0; k < 3; k++) begin
      check($sformatf("latency_nk%0d", 4 + 2*k), 128'(lat[k]), 128'(10 + 2*k));
      check($sformatf("result_nk%0d", 4 + 2*k), res_data[k], ref_aes(k, d, dec));
      check($sformatf("out_decrypt_nk%0d", 4 + 2*k), 128'(res_dec[k]), 128'(dec));
    end
    if (bp) begin
      repeat (5) begin
        @(posedge clk);
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
          check("bp_hold_data", out_data[k], res_data[k]);
          check("bp_count", 128'(cnt_w[k]), 128'(exp_cnt[k]));
        end
        check("bp_in_ready", 128'(in_ready), 128'(3'b000));
        check("bp_out_valid", 128'(out_valid), 128'(3'b111));
      end
      outReady = 1'b1;
    end
    @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      exp_cnt[k] = (exp_cnt[k] + 16'd1) & cnt_mask(k);
      check("block_count", 128'(cnt_w[k]), 128'(exp_cnt[k]));
    end
    check("idle_ready", 128'(in_ready), 128'(3'b111));
  endtask

  initial begin
    logic [127:0] d;
    logic         dec;
    logic [127:0] exp_wrap [3];
    logic [1:0]   prev;
    int           n;
    int           last;

    vectors     = 0;
    miscompares = 0;
    wrap_seq    = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
    build_tables();
    reset     = 1'b1;
    inValid   = 1'b0;
    inDecrypt = 1'b0;
    outReady  = 1'b1;
    inData    = '0;
    for (int k = 0; k < 3; k++) exp_cnt[k] = '0;
    set_key({128'h000102030405060708090a0b0c0d0e0f, 128'h101112131415161718191a1b1c1d1e1f});

    // Reset state
    @(negedge clk);
    check("rst_out_valid", 128'(out_valid), 128'(3'b000));
    check("rst_busy", 128'(busy), 128'(3'b000));
    check("rst_in_ready", 128'(in_ready), 128'(3'b111));
    check("rst_out_dec", 128'(out_dec), 128'(3'b000));
    for (int k = 0; k < 3; k++) begin
      check("rst_out_data", out_data[k], 128'h0);
      check("rst_count", 128'(cnt_w[k]), 128'h0);
    end
    reset = 1'b0;

    // Known-answer vectors
    launch(128'h00112233445566778899aabbccddeeff, 1'b0);
    collect(128'h00112233445566778899aabbccddeeff, 1'b0, 1'b0);
    check("kat_aes128", res_data[0], 128'h69c4e0d86a7b0430d8cdb78070b4c55a);
    check("kat_aes192", res_data[1], 128'hdda97ca4864cdfe06eaf70a0ec0d7191);
    check("kat_aes256", res_data[2], 128'h8ea2b7ca516745bfeafc49904b496089);
    check("kat_enc_mode", 128'(res_dec[0]), 128'h0);

    launch(128'h69c4e0d86a7b0430d8cdb78070b4c55a, 1'b1);
    collect(128'h69c4e0d86a7b0430d8cdb78070b4c55a, 1'b1, 1'b0);
    check("kat_aes128_dec", res_data[0], 128'h00112233445566778899aabbccddeeff);
    check("kat_dec_mode", 128'(res_dec[0]), 128'h1);

    // Random keys, blocks and directions
    for (int i = 0; i < 6; i++) begin
      set_key({rand128(), rand128()});
      d   = rand128();
      dec = 1'($urandom_range(0, 1));
      launch(d, dec);
      collect(d, dec, 1'b0);
    end

    // Back-pressure in DONE
    outReady = 1'b0;
    d = rand128();
    launch(d, 1'b0);
    collect(d, 1'b0, 1'b1);

    // Reset in the middle of round 5
    d = rand128();
    launch(d, 1'b0);
    repeat (4) begin
      @(posedge clk);
      @(negedge clk);
    end
    check("mid_busy", 128'(busy), 128'(3'b111));
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    check("abort_out_valid", 128'(out_valid), 128'(3'b000));
    check("abort_busy", 128'(busy), 128'(3'b000));
    check("abort_in_ready", 128'(in_ready), 128'(3'b111));
    for (int k = 0; k < 3; k++) begin
      exp_cnt[k] = '0;
      check("abort_count", 128'(cnt_w[k]), 128'h0);
    end
    d = rand128();
    launch(d, 1'b1);
    collect(d, 1'b1, 1'b0);

    // Back-to-back blocks with a 2-bit counter on the AES-128 core
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    for (int k = 0; k < 3; k++) exp_cnt[k] = '0;
    d = rand128();
    for (int k = 0; k < 3; k++) exp_wrap[k] = ref_aes(k, d, 1'b0);
    inData    = d;
    inDecrypt = 1'b0;
    inValid   = 1'b1;
    outReady  = 1'b1;
    prev = cnt4;
    n    = 0;
    last = 0;
    for (int cyc = 1; cyc <= 300 && !(inValid == 1'b0 && in_ready == 3'b111); cyc++) begin
      @(posedge clk);
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
        if (out_valid[k]) begin
          check("wrap_data", out_data[k], exp_wrap[k]);
          exp_cnt[k] = (exp_cnt[k] + 16'd1) & cnt_mask(k);
        end
      end
      if (cnt4 != prev && n < 5) begin
        check("wrap_seq", 128'(cnt4), 128'(wrap_seq[n]));
        if (n > 0) check("wrap_spacing", 128'(cyc - last), 128'(12));
        last = cyc;
        prev = cnt4;
        n++;
        if (n == 5) inValid = 1'b0;
      end
    end
    check("wrap_completions", 128'(n), 128'(5));
    for (int k = 0; k < 3; k++) check("wrap_final_count", 128'(cnt_w[k]), 128'(exp_cnt[k]));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
